// File: rtl/gate_vector_sequencer_pkg.sv
// gate_vector_sequencer_pkg: shared state encoding, gate bit positions and vector count
package gate_vector_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;
  localparam int GATE_W  = 7;
  localparam int G_NOT   = 6;
  localparam int G_AND   = 5;
  localparam int G_NAND  = 4;
  localparam int G_OR    = 3;
  localparam int G_NOR   = 2;
  localparam int G_XOR   = 1;
  localparam int G_XNOR  = 0;
endpackage

// File: rtl/gate_vector_sequencer_golden.sv
// gate_golden: combinational expected gate results for one operand pair
module gate_golden
  import gate_vector_sequencer_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [GATE_W-1:0] expected
);
  // one bit per gate, placed at its shared bit position
  always_comb begin
    expected         = '0;
    expected[G_NOT]  = ~a;
    expected[G_AND]  = a & b;
    expected[G_NAND] = ~(a & b);
    expected[G_OR]   = a | b;
    expected[G_NOR]  = ~(a | b);
    expected[G_XOR]  = a ^ b;
    expected[G_XNOR] = ~(a ^ b);
  end
endmodule

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: drives four operand vectors to a gate block and checks its results
module gate_vector_sequencer
  import gate_vector_sequencer_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  output logic               in_a,
  output logic               in_b,
  input  logic [GATE_W-1:0]  gate_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2:0]         err_count,
  output logic [NUM_VEC-1:0] fail_vec
);
  state_t             state_q, state_d;
  logic [VEC_W-1:0]   v_q, v_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, eff_q, eff_d;
  logic               in_a_q, in_a_d, in_b_q, in_b_d;
  logic [2:0]         err_q, err_d;
  logic [NUM_VEC-1:0] fail_q, fail_d;
  logic               pass_q, pass_d;
  logic [GATE_W-1:0]  expected;
  logic               last_tick, mismatch;

  gate_golden u_golden (
    .a        (in_a_q),
    .b        (in_b_q),
    .expected (expected)
  );

  assign last_tick = (state_q == ST_DRIVE) && (cnt_q == eff_q - 1'b1);
  assign mismatch  = gate_out != expected;

  // next state, vector/dwell counters and result accumulation
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    eff_d   = eff_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          v_d     = '0;
          cnt_d   = '0;
          eff_d   = (dwell == '0) ? DWELL_W'(1) : dwell;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (last_tick) begin
          cnt_d = '0;
          v_d   = v_q + 1'b1;
          if (mismatch) begin
            fail_d[v_q] = 1'b1;
            err_d       = err_q + 3'd1;
          end
          if (v_q == VEC_W'(NUM_VEC - 1)) begin
            state_d = ST_DONE;
            pass_d  = err_d == '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    in_a_d = (state_d == ST_DRIVE) & v_d[0];
    in_b_d = (state_d == ST_DRIVE) & v_d[1];
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      eff_q   <= '0;
      in_a_q  <= 1'b0;
      in_b_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      eff_q   <= eff_d;
      in_a_q  <= in_a_d;
      in_b_q  <= in_b_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign in_a      = in_a_q;
  assign in_b      = in_b_q;
  assign busy      = state_q != ST_IDLE;
  assign done      = state_q == ST_DONE;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb_gate_vector_sequencer: randomized checks of the sequencer against a behavioural model
module tb_gate_vector_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dwell = '0;
  logic       in_a, in_b, busy, done, pass;
  logic [6:0] gate_out;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [6:0] mask [4];
  logic [3:0] exp_fail;
  logic [2:0] exp_err;
  int n_cmp = 0;
  int n_bad = 0;

  gate_vector_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dwell(dwell),
    .in_a(in_a), .in_b(in_b), .gate_out(gate_out),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ideal(input logic a, input logic b);
    return {~a, a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  // gate block model: ideal results with per-vector injected corruption
  always_comb gate_out = ideal(in_a, in_b) ^ mask[{in_b, in_a}];

  task automatic model_results();
    exp_err = '0;
    for (int v = 0; v < 4; v++) begin
      exp_fail[v] = mask[v] != '0;
      exp_err     = exp_err + 3'(exp_fail[v]);
    end
  endtask

  task automatic set_masks(input logic [6:0] m0, input logic [6:0] m1, input logic [6:0] m2, input logic [6:0] m3);
    mask[0] = m0; mask[1] = m1; mask[2] = m2; mask[3] = m3;
    model_results();
  endtask

  task automatic random_masks();
    for (int v = 0; v < 4; v++) mask[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
    model_results();
  endtask

  task automatic run_check(input logic [7:0] dw, input bit glitch, input string name);
    int eff;
    logic [3:0] exp_sig;
    eff = (dw == 0) ? 1 : int'(dw);
    @(negedge clk);
    dwell = dw;
    start = 1'b1;
    for (int j = 0; j <= 4 * eff + 1; j++) begin
      int v;
      @(negedge clk);
      if (j == 0) start = 1'b0;
      v = j / eff;
      exp_sig = (j < 4 * eff) ? {1'(v & 1), 1'(v >> 1), 2'b10} : (j == 4 * eff) ? 4'b0011 : 4'b0000;
      n_cmp++;
      if ({in_a, in_b, busy, done} !== exp_sig) begin
        n_bad++;
        $display("FAIL %s cycle %0d {a,b,busy,done}: got %b want %b", name, j, {in_a, in_b, busy, done}, exp_sig);
      end
      if (j >= 4 * eff) begin
        n_cmp++;
        if ({pass, err_count, fail_vec} !== {exp_err == 0, exp_err, exp_fail}) begin
          n_bad++;
          $display("FAIL %s cycle %0d {pass,err,fail}: got %b_%0d_%b want %b_%0d_%b", name, j,
                   pass, err_count, fail_vec, exp_err == 0, exp_err, exp_fail);
        end
      end
      if (glitch && j == 5) dwell = 8'd3;
      if (glitch && j == 9) start = 1'b1;
      if (glitch && j == 10) start = 1'b0;
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s idle %0d busy/done: got %b%b want 00", name, j, busy, done);
      end
    end
  endtask

  task automatic test_reset();
    set_masks(0, 0, 0, 0);
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_a, in_b, busy, done, pass, err_count, fail_vec} !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 0", {in_a, in_b, busy, done, pass, err_count, fail_vec});
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_masks(0, 0, 0, 0);
    run_check(8'd20, 1'b0, "basic_dwell20");
  endtask

  task automatic test_xor_stuck();
    set_masks(0, 7'b0000010, 7'b0000010, 0);
    n_cmp++;
    if (exp_fail !== 4'b0110 || exp_err !== 3'd2) begin
      n_bad++;
      $display("FAIL xor_model: got %b/%0d want 0110/2", exp_fail, exp_err);
    end
    run_check(8'd2, 1'b0, "xor_stuck");
  endtask

  task automatic test_reset_clears();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({pass, err_count, fail_vec} !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_clears_results: got %b want 0", {pass, err_count, fail_vec});
    end
  endtask

  task automatic test_dwell_zero();
    random_masks();
    run_check(8'd0, 1'b0, "dwell_zero");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      random_masks();
      run_check(8'($urandom_range(0, 6)), 1'b0, "random");
    end
    random_masks();
    run_check(8'hFF, 1'b0, "dwell_max");
  endtask

  task automatic test_midrun_reset();
    set_masks(0, 0, 0, 0);
    @(negedge clk);
    dwell = 8'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    n_cmp++;
    if ({in_a, in_b, busy, done, pass, err_count, fail_vec} !== 12'd0) begin
      n_bad++;
      $display("FAIL midrun_reset outputs: got %b want 0", {in_a, in_b, busy, done, pass, err_count, fail_vec});
    end
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL midrun_reset idle %0d busy/done: got %b%b want 00", j, busy, done);
      end
    end
    random_masks();
    run_check(8'd20, 1'b0, "after_reset");
  endtask

  task automatic test_midrun_start();
    random_masks();
    run_check(8'd20, 1'b1, "midrun_start_dwell");
  endtask

  task automatic test_back_to_back();
    int dones;
    random_masks();
    dones = 0;
    @(negedge clk);
    dwell = 8'd4;
    start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      int j;
      logic [3:0] exp_sig;
      @(negedge clk);
      j = c % 18;
      exp_sig = (j < 16) ? {1'((j / 4) & 1), 1'((j / 4) >> 1), 2'b10} : (j == 16) ? 4'b0011 : 4'b0000;
      dones += int'(done);
      n_cmp++;
      if ({in_a, in_b, busy, done} !== exp_sig) begin
        n_bad++;
        $display("FAIL b2b cycle %0d {a,b,busy,done}: got %b want %b", c, {in_a, in_b, busy, done}, exp_sig);
      end
      if (j >= 16) begin
        n_cmp++;
        if ({pass, err_count, fail_vec} !== {exp_err == 0, exp_err, exp_fail}) begin
          n_bad++;
          $display("FAIL b2b cycle %0d results: got %b_%0d_%b want %b_%0d_%b", c,
                   pass, err_count, fail_vec, exp_err == 0, exp_err, exp_fail);
        end
      end
      if (j == 17) random_masks();
    end
    start = 1'b0;
    n_cmp++;
    if (dones != 11) begin
      n_bad++;
      $display("FAIL b2b done_count: got %0d want 11", dones);
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b wind_down busy: got %b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_xor_stuck();
    test_reset_clears();
    test_dwell_zero();
    test_random();
    test_midrun_reset();
    test_midrun_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
